sample_feeder: RTL

- Transmit-side source for the FIR filter sockets.
- Buffers samples written by a loader (testbench or upstream block) in a small FIFO.
- Emits one sample every DIV clocks on input_sig, with a one-cycle ready strobe, to drive the input_sig/ready pair of the filter sockets at the decimated sample rate they consume.
- Reports buffer status, underrun/overflow and a count of samples sent.

---
 rtl/sample_feeder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sample_feeder.sv
// ---------------------------------------------------------------------------
// sample_feeder: buffers loader samples and emits one every DIV clocks with a
// one-cycle ready strobe.                                          Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sample_feeder #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int DIV   = 128,
   parameter int CNT_W = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] input_sig,
   output logic             ready,
   output logic             underrun,
   output logic             overflow,
   output logic [CNT_W-1:0] sent_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = $clog2(DIV);
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

   logic [DW-1:0]    div_q, div_d;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             full_q, empty_q;
   logic [WIDTH-1:0] sig_q, sig_d;
   logic             ready_q, ready_d;
   logic             under_q, under_d;
   logic             over_q, over_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic tick, pop, push, occ_full, occ_empty;

   // Occupancy is judged on the count before this cycle's write.
   always_comb begin
      tick      = enable && (div_q == DIV_LAST);
      occ_full  = (count_q == DEPTH_CNT);
      occ_empty = (count_q == '0);
      pop       = tick && !occ_empty;
      push      = wr_en && (!occ_full || pop);
   end

   always_comb begin
      div_d = '0;
      if (enable && !tick) begin
         div_d = div_q + 1'b1;
      end

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      sig_d   = sig_q;
      ready_d = 1'b0;
      cnt_d   = cnt_q;
      if (pop) begin
         sig_d   = mem_q[rd_ptr_q];
         ready_d = 1'b1;
         cnt_d   = cnt_q + 1'b1;
      end

      under_d = under_q || (tick && occ_empty);
      over_d  = over_q || (wr_en && occ_full && !pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         sig_q    <= '0;
         ready_q  <= 1'b0;
         under_q  <= 1'b0;
         over_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         div_q    <= div_d;
         wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
         rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
         count_q  <= count_d;
         full_q   <= (count_d == DEPTH_CNT);
         empty_q  <= (count_d == '0);
         sig_q    <= sig_d;
         ready_q  <= ready_d;
         under_q  <= under_d;
         over_q   <= over_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign full      = full_q;
   assign empty     = empty_q;
   assign input_sig = sig_q;
   assign ready     = ready_q;
   assign underrun  = under_q;
   assign overflow  = over_q;
   assign sent_cnt  = cnt_q;

endmodule

`default_nettype wire
